// File: rtl/vga_pkg.sv
// Timing constants for 640x480@60 Hz VGA and the sync polarity.
package vga_pkg;

   // Horizontal timing, in pixels
   localparam int VGA_H_VIS  = 640;
   localparam int VGA_H_FP   = 16;
   localparam int VGA_H_SYNC = 96;
   localparam int VGA_H_BP   = 48;
   localparam int VGA_H_TOT  = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

   // Vertical timing, in lines
   localparam int VGA_V_VIS  = 480;
   localparam int VGA_V_FP   = 10;
   localparam int VGA_V_SYNC = 2;
   localparam int VGA_V_BP   = 33;
   localparam int VGA_V_TOT  = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

   // System clocks per pixel (50 MHz -> 25 MHz pixel clock)
   localparam int VGA_CLK_DIV = 2;

   // Level the sync pins take while inside the sync pulse
   localparam logic VGA_SYNC_ACT = 1'b0;

   // Coordinate width of DrawX/DrawY
   localparam int VGA_CW = 10;

endpackage

// File: rtl/vga_pix_div.sv
// Clock divider producing a registered one-Clk pixel enable every CLK_DIV Clk.
module vga_pix_div #(
   parameter int CLK_DIV = 2
) (
   input  logic Clk,
   input  logic Reset_n,
   output logic pixel_ce
);

   // A single-bit counter still exists for CLK_DIV=1; it simply stays at 0.
   localparam int              DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0]   DIV_MAX = DW'(CLK_DIV - 1);

   logic [DW-1:0] div;

   // Divider wraps at CLK_DIV-1; pixel_ce follows the terminal count by one Clk.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         div      <= '0;
         pixel_ce <= 1'b0;
      end else begin
         div      <= (div == DIV_MAX) ? '0 : div + DW'(1);
         pixel_ce <= (div == DIV_MAX);
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counters, sync/blank generation and registered RGB output for VGA.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int CLK_DIV = VGA_CLK_DIV,
   parameter int H_VIS   = VGA_H_VIS,
   parameter int H_FP    = VGA_H_FP,
   parameter int H_SYNC  = VGA_H_SYNC,
   parameter int H_BP    = VGA_H_BP,
   parameter int V_VIS   = VGA_V_VIS,
   parameter int V_FP    = VGA_V_FP,
   parameter int V_SYNC  = VGA_V_SYNC,
   parameter int V_BP    = VGA_V_BP
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic [7:0]        Red,
   input  logic [7:0]        Green,
   input  logic [7:0]        Blue,
   output logic [VGA_CW-1:0] DrawX,
   output logic [VGA_CW-1:0] DrawY,
   output logic              pixel_ce,
   output logic              frame_tick,
   output logic [7:0]        frame_cnt,
   output logic              VGA_HS,
   output logic              VGA_VS,
   output logic              VGA_BLANK_N,
   output logic              VGA_SYNC_N,
   output logic [7:0]        VGA_R,
   output logic [7:0]        VGA_G,
   output logic [7:0]        VGA_B
);

   localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

   // Counter-width versions of the timing points, so compares stay width-matched.
   localparam logic [VGA_CW-1:0] HC_MAX  = VGA_CW'(H_TOT - 1);
   localparam logic [VGA_CW-1:0] VC_MAX  = VGA_CW'(V_TOT - 1);
   localparam logic [VGA_CW-1:0] H_VIS_C = VGA_CW'(H_VIS);
   localparam logic [VGA_CW-1:0] V_VIS_C = VGA_CW'(V_VIS);
   localparam logic [VGA_CW-1:0] HS_BEG  = VGA_CW'(H_VIS + H_FP);
   localparam logic [VGA_CW-1:0] HS_END  = VGA_CW'(H_VIS + H_FP + H_SYNC);
   localparam logic [VGA_CW-1:0] VS_BEG  = VGA_CW'(V_VIS + V_FP);
   localparam logic [VGA_CW-1:0] VS_END  = VGA_CW'(V_VIS + V_FP + V_SYNC);
   localparam logic [VGA_CW-1:0] VL_LAST = VGA_CW'(V_VIS - 1);

   logic [VGA_CW-1:0] hc;
   logic [VGA_CW-1:0] vc;
   logic              hs_raw;
   logic              vs_raw;
   logic              vis_raw;
   logic              vblank_start;

   vga_pix_div #(
      .CLK_DIV (CLK_DIV)
   ) u_pix_div (
      .Clk      (Clk),
      .Reset_n  (Reset_n),
      .pixel_ce (pixel_ce)
   );

   // Pixel/line counters, advancing once per pixel enable.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         hc <= '0;
         vc <= '0;
      end else if (pixel_ce) begin
         if (hc == HC_MAX) begin
            hc <= '0;
            vc <= (vc == VC_MAX) ? '0 : vc + VGA_CW'(1);
         end else begin
            hc <= hc + VGA_CW'(1);
         end
      end
   end

   assign DrawX      = hc;
   assign DrawY      = vc;
   assign VGA_SYNC_N = 1'b0;

   // Raw sync/visibility decode of the current counter position.
   always_comb begin
      hs_raw  = ~VGA_SYNC_ACT;
      vs_raw  = ~VGA_SYNC_ACT;
      vis_raw = (hc < H_VIS_C) && (vc < V_VIS_C);
      if ((hc >= HS_BEG) && (hc < HS_END)) hs_raw = VGA_SYNC_ACT;
      if ((vc >= VS_BEG) && (vc < VS_END)) vs_raw = VGA_SYNC_ACT;
   end

   // True on the edge that moves the raster from the last visible line to (0, V_VIS).
   assign vblank_start = pixel_ce && (hc == HC_MAX) && (vc == VL_LAST);

   // Frame tick is raised on that same edge, so it is high for the first Clk at (0, V_VIS).
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         frame_tick <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         frame_tick <= vblank_start;
         if (vblank_start) frame_cnt <= frame_cnt + 8'd1;
      end
   end

   // One pixel stage: sync, blank and colour move together so they stay aligned.
   // Colour is sampled from the combinational color_mapper on the same edge as the
   // coordinates that produced it, and forced to black outside the visible area.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         VGA_HS      <= ~VGA_SYNC_ACT;
         VGA_VS      <= ~VGA_SYNC_ACT;
         VGA_BLANK_N <= 1'b0;
         VGA_R       <= '0;
         VGA_G       <= '0;
         VGA_B       <= '0;
      end else if (pixel_ce) begin
         VGA_HS      <= hs_raw;
         VGA_VS      <= vs_raw;
         VGA_BLANK_N <= vis_raw;
         VGA_R       <= vis_raw ? Red   : 8'd0;
         VGA_G       <= vis_raw ? Green : 8'd0;
         VGA_B       <= vis_raw ? Blue  : 8'd0;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a shrunken raster (8x7) so that
// hundreds of frames fit in a short run.
module tb_vga_timing_gen;

   localparam int CLK_DIV = 2;
   localparam int H_VIS = 4, H_FP = 1, H_SYNC = 2, H_BP = 1;
   localparam int V_VIS = 3, V_FP = 1, V_SYNC = 2, V_BP = 1;
   localparam int H_TOT = 8;           // 4+1+2+1
   localparam int V_TOT = 7;           // 3+1+2+1
   localparam int FT    = 56;          // pixels per frame
   localparam int VB_P  = 24;          // pixel index of (0, V_VIS)

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       ce;
      logic       ft;
      logic [7:0] fc;
      logic       hs;
      logic       vs;
      logic       bn;
      logic       sn;
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } vec_t;

   logic       Clk = 1'b0;
   logic       Reset_n;
   logic [7:0] Red, Green, Blue;
   logic [9:0] DrawX, DrawY;
   logic       pixel_ce, frame_tick;
   logic [7:0] frame_cnt;
   logic       VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
   logic [7:0] VGA_R, VGA_G, VGA_B;

   vec_t q[$];
   int   n_vec = 0;
   int   n_fail = 0;
   int   k = 0;
   logic meas_on = 1'b0;
   logic agg_req = 1'b0;
   int   ticks_seen = 0;
   int   hs_run = 0;
   int   hs_first = 0;

   vga_timing_gen #(
      .CLK_DIV(CLK_DIV), .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Red(Red), .Green(Green), .Blue(Blue),
      .DrawX(DrawX), .DrawY(DrawY), .pixel_ce(pixel_ce), .frame_tick(frame_tick),
      .frame_cnt(frame_cnt), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
      .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N),
      .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
   );

   always #5 Clk = ~Clk;

   // Combinational stand-in for color_mapper; drives 8'hff red when off-screen.
   assign Red   = (DrawX >= 10'(H_VIS) || DrawY >= 10'(V_VIS)) ? 8'hff : DrawX[7:0];
   assign Green = DrawY[7:0] ^ 8'h5A;
   assign Blue  = {DrawX[3:0], DrawY[3:0]};

   // Pixels advanced after k Clk edges since reset release.
   function automatic int p_of(input int kk);
      return (kk >= 1) ? (kk - 1) / CLK_DIV : 0;
   endfunction

   // Closed-form expectation of every output after kk edges since release.
   function automatic vec_t expect_at(input int kk);
      vec_t e;
      int p, q1, ph, pv;
      p = p_of(kk);
      e = '0;
      e.x  = 10'(p % H_TOT);
      e.y  = 10'((p / H_TOT) % V_TOT);
      e.ce = (kk >= 1) && (kk % CLK_DIV == 0);
      e.ft = (p > 0) && ((kk - 1) % CLK_DIV == 0) && (p % FT == VB_P);
      e.fc = (p < VB_P) ? 8'd0 : 8'(((p - VB_P) / FT + 1) % 256);
      e.sn = 1'b0;
      if (p == 0) begin
         e.hs = 1'b1; e.vs = 1'b1; e.bn = 1'b0;
      end else begin
         q1 = p - 1;
         ph = q1 % H_TOT;
         pv = (q1 / H_TOT) % V_TOT;
         e.hs = !(ph >= H_VIS + H_FP && ph < H_VIS + H_FP + H_SYNC);
         e.vs = !(pv >= V_VIS + V_FP && pv < V_VIS + V_FP + V_SYNC);
         e.bn = (ph < H_VIS) && (pv < V_VIS);
         if (e.bn) begin
            e.r = 8'(ph);
            e.g = 8'(pv) ^ 8'h5A;
            e.b = 8'((ph % 16) * 16 + (pv % 16));
         end
      end
      return e;
   endfunction

   task automatic step();
      @(posedge Clk); #1;
      if (Reset_n) k++;
      q.push_back(expect_at(k));
   endtask

   task automatic rst_step();
      @(posedge Clk); #1;
      Reset_n = 1'b0;
      k = 0;
      q.push_back(expect_at(0));
   endtask

   task automatic release_rst();
      @(posedge Clk); #1;
      Reset_n = 1'b1;
      k = 0;
      q.push_back(expect_at(0));
   endtask

   // Monitor: pops one expectation per sampled cycle and compares all outputs.
   always @(negedge Clk) begin
      vec_t a, e;
      if (q.size() > 0) begin
         e = q.pop_front();
         a = {DrawX, DrawY, pixel_ce, frame_tick, frame_cnt, VGA_HS, VGA_VS,
              VGA_BLANK_N, VGA_SYNC_N, VGA_R, VGA_G, VGA_B};
         n_vec++;
         if (a !== e) begin
            n_fail++;
            if (n_fail <= 20)
               $display("FAIL raster t=%0t got x=%0d y=%0d ce=%b ft=%b fc=%0d hs=%b vs=%b bn=%b sn=%b rgb=%h_%h_%h exp x=%0d y=%0d ce=%b ft=%b fc=%0d hs=%b vs=%b bn=%b sn=%b rgb=%h_%h_%h",
                        $time, a.x, a.y, a.ce, a.ft, a.fc, a.hs, a.vs, a.bn, a.sn, a.r, a.g, a.b,
                        e.x, e.y, e.ce, e.ft, e.fc, e.hs, e.vs, e.bn, e.sn, e.r, e.g, e.b);
         end
      end
      if (meas_on) begin
         if (frame_tick) ticks_seen++;
         if (!VGA_HS) hs_run++;
         else begin
            if (hs_run > 0 && hs_first == 0) hs_first = hs_run;
            hs_run = 0;
         end
      end
      if (agg_req) begin
         agg_req = 1'b0;
         n_vec++;
         if (ticks_seen != 256) begin
            n_fail++;
            $display("FAIL frame_tick_count got %0d exp 256", ticks_seen);
         end
         n_vec++;
         if (hs_first != H_SYNC * CLK_DIV) begin
            n_fail++;
            $display("FAIL hsync_width_clk got %0d exp %0d", hs_first, H_SYNC * CLK_DIV);
         end
      end
   end

   initial begin
      Reset_n = 1'b0;
      repeat (3) step();
      release_rst();
      // Run into the second frame, then reset asynchronously mid-line.
      while (p_of(k) != FT + H_TOT + 3) step();
      rst_step();
      repeat (3) step();
      release_rst();
      meas_on = 1'b1;
      // 28700 edges -> 14349 pixels: exactly 256 frame ticks, frame_cnt back to 0.
      repeat (28700) step();
      @(negedge Clk); #1;
      meas_on = 1'b0;
      agg_req = 1'b1;
      repeat (3) @(negedge Clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster source for the display path: generates DrawX/DrawY, the coordinates color_mapper consumes, plus the 640x480@60 Hz sync timing.
- Registers the Red/Green/Blue returned by color_mapper into the VGA output pins, delaying sync and blank to match.
- Emits a once-per-frame tick and a free-running frame counter, used for game-state updates and sprite animation (e.g. pac chomp phase).

Parameters:
- CLK_DIV, 2, system clocks per pixel; pixel enable asserts every CLK_DIV-th Clk; minimum 1.
- H_VIS, 640, visible pixels per line.
- H_FP, 16, horizontal front porch, in pixels.
- H_SYNC, 96, hsync width, in pixels.
- H_BP, 48, horizontal back porch, in pixels.
- V_VIS, 480, visible lines.
- V_FP, 10, vertical front porch, in lines.
- V_SYNC, 2, vsync width, in lines.
- V_BP, 33, vertical back porch, in lines.

Ports:
- Clk  in  1  system clock (50 MHz).
- Reset_n  in  1  asynchronous, active-low reset.
- Red  in  8  color_mapper red for the current DrawX/DrawY.
- Green  in  8  color_mapper green.
- Blue  in  8  color_mapper blue.
- DrawX  out  10  current pixel column, 0..H_TOT-1.
- DrawY  out  10  current line, 0..V_TOT-1.
- pixel_ce  out  1  one-Clk pulse marking each pixel boundary.
- frame_tick  out  1  one-Clk pulse at the start of vertical blank.
- frame_cnt  out  8  frames completed since reset; wraps.
- VGA_HS  out  1  horizontal sync, active low.
- VGA_VS  out  1  vertical sync, active low.
- VGA_BLANK_N  out  1  low outside the visible area.
- VGA_SYNC_N  out  1  tied 0.
- VGA_R  out  8  registered red.
- VGA_G  out  8  registered green.
- VGA_B  out  8  registered blue.

Behaviour:
- Reset/clocking: one clock (Clk); reset is asynchronous and active-low (Reset_n). All state is cleared asynchronously while Reset_n=0.
- Reset values:
  - div counter 0; hc=vc=0, so DrawX=DrawY=0.
  - pixel_ce=0, frame_tick=0, frame_cnt=0.
  - VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, VGA_R/G/B=0.
- Derived constants: H_TOT=H_VIS+H_FP+H_SYNC+H_BP (800); V_TOT=V_VIS+V_FP+V_SYNC+V_BP (525).
- Divider:
  - Counts 0..CLK_DIV-1 and wraps.
  - pixel_ce is registered; it is 1 in the Clk cycle after the divider reaches CLK_DIV-1.
  - With CLK_DIV=1, pixel_ce is constantly 1 after the first post-reset edge.
  - First pixel_ce occurs CLK_DIV Clk edges after reset release.
- Counters:
  - Both advance only on Clk edges where pixel_ce=1.
  - hc increments; at H_TOT-1 it wraps to 0 and vc increments.
  - vc wraps from V_TOT-1 to 0 only on the hc wrap.
  - DrawX=hc and DrawY=vc, driven directly from registers.
- Raw timing, combinational on hc/vc:
  - hs_raw=0 iff H_VIS+H_FP <= hc < H_VIS+H_FP+H_SYNC (656..751).
  - vs_raw=0 iff V_VIS+V_FP <= vc < V_VIS+V_FP+V_SYNC (490..491).
  - vis_raw = (hc<H_VIS) && (vc<V_VIS).
- Output pipeline, one pixel stage, updating only when pixel_ce=1:
  - VGA_HS<=hs_raw, VGA_VS<=vs_raw, VGA_BLANK_N<=vis_raw.
  - VGA_R/G/B <= vis_raw ? Red/Green/Blue : 0.
  - Red/Green/Blue are sampled on the same edge as the DrawX/DrawY that produced them, so color_mapper must be combinational.
  - Output latency from DrawX change to pin change: exactly one pixel_ce period. Sync, blank and RGB stay mutually aligned.
- frame_tick:
  - One-Clk pulse, asserted in the Clk cycle after the counters move to hc=0, vc=V_VIS (480).
  - Exactly one pulse per frame.
  - frame_cnt increments by 1 on the same edge that raises frame_tick; 8-bit wrap 255->0.
- Reset mid-frame: counters and outputs return to their reset values immediately; the first frame after release starts at (0,0), with no frame_tick before vc reaches 480.
- Inputs are ignored while blanked: RGB is forced to 0 even if color_mapper drives nonzero (e.g. DrawX>=640).

Decomposition:
- Package vga_pkg holds the timing constants (H_VIS..V_BP, H_TOT, V_TOT) and the sync-polarity constant.
- Natural sub-module: vga_pix_div (divider plus pixel_ce generator), reusable by other pixel-rate blocks.

Test Plan:
- Reset: Reset_n=0, then release -> DrawX=DrawY=0, VGA_BLANK_N=0, VGA_HS=VGA_VS=1, frame_cnt=0; first pixel_ce 2 Clk edges after release.
- Line timing, CLK_DIV=2 -> pixel_ce period 2 Clk; hc wraps 799->0 every 1600 Clk; VGA_HS low for exactly 96 pixel_ce periods, starting one pixel after hc=656.
- Frame timing -> vc wraps 524->0 after 420000 pixel_ce; VGA_VS low for 2 lines (1600 pixel_ce) starting at vc=490 plus one pixel; frame_tick pulses once per 420000 pixel_ce, 1 Clk wide.
- RGB alignment: drive Red=DrawX[7:0] combinationally -> VGA_R equals the previous pixel's DrawX[7:0] while VGA_BLANK_N=1; VGA_R=0 for hc>=640 or vc>=480 even with Red=8'hff.
- Frame counter wrap: run 256 frames -> frame_cnt 255->0; exactly 256 frame_tick pulses.
- Async reset mid-line: assert Reset_n=0 at hc=300, vc=100 between edges -> outputs reset without waiting for Clk; after release, raster restarts at (0,0) and no frame_tick occurs until vc=480.
